// File: rtl/n64_download_pkg.sv
// Shared types and helpers for the N64 cartridge download path: ROM byte-order
// formats, packer FSM states, header magic halfwords and the byte-swap packer.
package n64_download_pkg;

  typedef enum logic [1:0] {
    FmtZ64     = 2'd0,
    FmtV64     = 2'd1,
    FmtN64     = 2'd2,
    FmtUnknown = 2'd3
  } rom_format_e;

  typedef enum logic [2:0] {
    StIdle,
    StDetect,
    StStream,
    StFlush,
    StDone
  } dl_state_e;

  localparam logic [15:0] MagicZ64 = 16'h3780;
  localparam logic [15:0] MagicV64 = 16'h8037;
  localparam logic [15:0] MagicN64 = 16'h1240;

  function automatic rom_format_e classify(input logic [15:0] hw);
    if (hw == MagicZ64)      return FmtZ64;
    else if (hw == MagicV64) return FmtV64;
    else if (hw == MagicN64) return FmtN64;
    else                     return FmtUnknown;
  endfunction

  // File bytes f0..f3 reordered so that bit [7:0] of the result is ROM byte 0.
  function automatic logic [31:0] pack_word(input rom_format_e fmt, input logic [15:0] h0,
                                            input logic [15:0] h1);
    logic [7:0] f0, f1, f2, f3;
    f0 = h0[7:0];
    f1 = h0[15:8];
    f2 = h1[7:0];
    f3 = h1[15:8];
    case (fmt)
      FmtV64:  return {f2, f3, f0, f1};
      FmtN64:  return {f0, f1, f2, f3};
      default: return {f3, f2, f1, f0};
    endcase
  endfunction

endpackage

// File: rtl/download_fifo.sv
// Synchronous FIFO with combinational head read and occupancy count.
module download_fifo #(
  parameter int unsigned Width = 59,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] CountFull = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CountFull);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    push_ok  = push_i && !full_o;
    pop_ok   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q + PtrW'(push_ok);
    rd_ptr_d = rd_ptr_q + PtrW'(pop_ok);
    count_d  = count_q + (PtrW + 1)'(push_ok) - (PtrW + 1)'(pop_ok);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/rom_download_packer.sv
// Packs a halfword cartridge download stream into byte-order-corrected 32-bit
// SDRAM write requests, with back-pressure and a single outstanding request.
module rom_download_packer
  import n64_download_pkg::*;
#(
  parameter int unsigned CART_START = 1048576,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk1x,
  input  logic        reset_n,
  input  logic        dl_active,
  input  logic [26:0] dl_addr,
  input  logic [15:0] dl_data,
  input  logic        dl_wr,
  output logic        dl_wait,
  output logic        mem_req,
  output logic [26:0] mem_addr,
  output logic [31:0] mem_data,
  input  logic        mem_ready,
  output logic [1:0]  rom_format,
  output logic [26:0] rom_size,
  output logic        load_done,
  output logic        overflow
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW:0] OccFull = (CntW + 1)'(FIFO_DEPTH);
  localparam logic [CntW:0] OccWait = (CntW + 1)'(FIFO_DEPTH - 1);
  localparam logic [26:0]   CartBase = 27'(CART_START);

  dl_state_e   state_q, state_d;
  rom_format_e fmt_q, fmt_d;
  logic        dl_active_q, start_pend_q, start_pend_d;
  logic [26:0] size_q, size_d;
  logic        ovf_q, ovf_d;
  logic [15:0] h0_q, h0_d;
  logic        h0_vld_q, h0_vld_d;
  logic [24:0] h0_waddr_q, h0_waddr_d;
  logic        push_q, push_d;
  logic [26:0] push_addr_q, push_addr_d;
  logic [31:0] push_data_q, push_data_d;
  logic        out_q, out_d, req_q, req_d, wait_q, wait_d;
  logic [26:0] maddr_q, maddr_d;
  logic [31:0] mdata_q, mdata_d;

  logic [58:0]     fifo_rdata;
  logic            fifo_empty, fifo_full, pop;
  logic [CntW-1:0] fifo_count;
  logic [CntW:0]   occ;
  logic            rise, window, full_eff, wr_ok;
  logic [26:0]     next_end;

  download_fifo #(
    .Width (59),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk1x),
    .rst_ni  (reset_n),
    .push_i  (push_q),
    .wdata_i ({push_addr_q, push_data_q}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    fmt_d        = fmt_q;
    start_pend_d = start_pend_q;
    size_d       = size_q;
    ovf_d        = ovf_q;
    h0_d         = h0_q;
    h0_vld_d     = h0_vld_q;
    h0_waddr_d   = h0_waddr_q;
    push_d       = 1'b0;
    push_addr_d  = push_addr_q;
    push_data_d  = push_data_q;
    out_d        = out_q;
    req_d        = 1'b0;
    maddr_d      = maddr_q;
    mdata_d      = mdata_q;

    // A word registered for push still counts against capacity.
    occ      = (CntW + 1)'(fifo_count) + (CntW + 1)'(push_q);
    rise     = dl_active && !dl_active_q;
    window   = (state_q == StDetect) || (state_q == StStream);
    full_eff = (occ >= OccFull);
    wr_ok    = dl_wr && window && !full_eff;
    next_end = dl_addr + 27'd2;
    wait_d   = (occ >= OccWait) || (state_q == StFlush) || (state_q == StDone);

    if (dl_wr && window && full_eff) ovf_d = 1'b1;

    if (wr_ok) begin
      if (dl_addr == '0) fmt_d = classify(dl_data);
      if (next_end > size_q) size_d = next_end;
      if (!dl_addr[1]) begin
        h0_d       = dl_data;
        h0_vld_d   = 1'b1;
        h0_waddr_d = dl_addr[26:2];
      end else begin
        push_d      = 1'b1;
        push_data_d = pack_word(fmt_q, h0_q, dl_data);
        push_addr_d = CartBase + {dl_addr[26:2], 2'b00};
        h0_vld_d    = 1'b0;
      end
    end

    // Odd tail: the lone h0 goes out with a zero upper halfword.
    if (state_q == StFlush && h0_vld_q && !full_eff) begin
      push_d      = 1'b1;
      push_data_d = pack_word(fmt_q, h0_q, 16'h0000);
      push_addr_d = CartBase + {h0_waddr_q, 2'b00};
      h0_vld_d    = 1'b0;
    end

    pop = mem_ready && out_q;
    if (pop) out_d = 1'b0;
    if (!out_q && !fifo_empty) begin
      req_d   = 1'b1;
      out_d   = 1'b1;
      maddr_d = fifo_rdata[58:32];
      mdata_d = fifo_rdata[31:0];
    end

    if (rise && (state_q == StFlush || state_q == StDone)) start_pend_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (rise || start_pend_q) begin
          state_d      = StDetect;
          start_pend_d = 1'b0;
          size_d       = '0;
          ovf_d        = 1'b0;
          h0_d         = '0;
          h0_vld_d     = 1'b0;
          fmt_d        = FmtZ64;
        end
      end
      StDetect: begin
        if (!dl_active)  state_d = StFlush;
        else if (wr_ok)  state_d = StStream;
      end
      StStream: if (!dl_active) state_d = StFlush;
      StFlush: begin
        if (fifo_empty && !out_q && !push_q && !h0_vld_q) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk1x or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      fmt_q        <= FmtZ64;
      dl_active_q  <= 1'b0;
      start_pend_q <= 1'b0;
      size_q       <= '0;
      ovf_q        <= 1'b0;
      h0_q         <= '0;
      h0_vld_q     <= 1'b0;
      h0_waddr_q   <= '0;
      push_q       <= 1'b0;
      push_addr_q  <= '0;
      push_data_q  <= '0;
      out_q        <= 1'b0;
      req_q        <= 1'b0;
      maddr_q      <= '0;
      mdata_q      <= '0;
      wait_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fmt_q        <= fmt_d;
      dl_active_q  <= dl_active;
      start_pend_q <= start_pend_d;
      size_q       <= size_d;
      ovf_q        <= ovf_d;
      h0_q         <= h0_d;
      h0_vld_q     <= h0_vld_d;
      h0_waddr_q   <= h0_waddr_d;
      push_q       <= push_d;
      push_addr_q  <= push_addr_d;
      push_data_q  <= push_data_d;
      out_q        <= out_d;
      req_q        <= req_d;
      maddr_q      <= maddr_d;
      mdata_q      <= mdata_d;
      wait_q       <= wait_d;
    end
  end

  assign dl_wait    = wait_q;
  assign mem_req    = req_q;
  assign mem_addr   = maddr_q;
  assign mem_data   = mdata_q;
  assign rom_format = fmt_q;
  assign rom_size   = size_q;
  assign load_done  = (state_q == StDone);
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_rom_download_packer.sv
// Scoreboard bench for rom_download_packer: stimulus queues expected SDRAM
// writes, a monitor pops and compares them on every mem_req.
module tb_rom_download_packer;

  logic        clk1x     = 1'b0;
  logic        reset_n   = 1'b0;
  logic        dl_active = 1'b0;
  logic [26:0] dl_addr   = '0;
  logic [15:0] dl_data   = '0;
  logic        dl_wr     = 1'b0;
  logic        mem_ready = 1'b0;
  logic        dl_wait, mem_req, load_done, overflow;
  logic [26:0] mem_addr, rom_size;
  logic [31:0] mem_data;
  logic [1:0]  rom_format;

  typedef struct packed {
    logic [26:0] a;
    logic [31:0] d;
  } exp_t;

  exp_t        exp_q [$];
  logic [15:0] vec [$];
  int          tests = 0, fails = 0;
  int          load_done_cnt = 0, req_cnt = 0;
  int          ready_delay = 2;
  bit          resp_en = 1'b1;
  int          stale_pulses = 0, stale_done = 0;
  bit          bp_arm = 1'b0, bp_seen = 1'b0;
  int          occ = 0, occ_old = 0;
  bit          pend_h1 = 1'b0, pend_ack = 1'b0, mon_out = 1'b0;
  logic [26:0] cap_a;
  logic [31:0] cap_d;

  rom_download_packer #(
    .CART_START (1048576),
    .FIFO_DEPTH (4)
  ) dut (
    .clk1x      (clk1x),
    .reset_n    (reset_n),
    .dl_active  (dl_active),
    .dl_addr    (dl_addr),
    .dl_data    (dl_data),
    .dl_wr      (dl_wr),
    .dl_wait    (dl_wait),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .rom_format (rom_format),
    .rom_size   (rom_size),
    .load_done  (load_done),
    .overflow   (overflow)
  );

  always #5 clk1x = ~clk1x;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [26:0] a, input logic [31:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Monitor: scoreboard, request stability, load_done count, occupancy model.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk1x);
      if (!reset_n) begin
        mon_out  = 1'b0;
        occ      = 0;
        pend_h1  = 1'b0;
        pend_ack = 1'b0;
      end else begin
        occ_old = occ;
        occ     = occ + int'(pend_h1) - int'(pend_ack);
        if (bp_arm && !bp_seen && dl_wait) begin
          check("bp_wait_occupancy", 128'(occ_old), 128'(3));
          bp_seen = 1'b1;
        end
        pend_h1  = dl_wr && dl_addr[1];
        pend_ack = mem_ready && mon_out;
        if (mem_ready && mon_out) begin
          check("req_addr_stable", 128'(mem_addr), 128'(cap_a));
          check("req_data_stable", 128'(mem_data), 128'(cap_d));
          mon_out = 1'b0;
        end
        if (mem_req) begin
          req_cnt++;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_req: got addr %0h data %0h, expected no request",
                     mem_addr, mem_data);
          end else begin
            e = exp_q.pop_front();
            check("mem_addr", 128'(mem_addr), 128'(e.a));
            check("mem_data", 128'(mem_data), 128'(e.d));
          end
          cap_a   = mem_addr;
          cap_d   = mem_data;
          mon_out = 1'b1;
        end
        if (load_done) load_done_cnt++;
      end
    end
  end

  // SDRAM responder: acknowledges each request after ready_delay cycles.
  initial begin
    forever begin
      @(posedge clk1x);
      #1;
      mem_ready = 1'b0;
      if (stale_done != stale_pulses) begin
        mem_ready = 1'b1;
        stale_done++;
      end else if (resp_en && mem_req && reset_n) begin
        repeat (ready_delay) @(posedge clk1x);
        #1;
        mem_ready = 1'b1;
      end
    end
  end

  task automatic send(input logic [26:0] a, input logic [15:0] d);
    int guard = 0;
    while (dl_wait && guard < 2000) begin
      @(posedge clk1x);
      #1;
      guard++;
    end
    check("dl_wait_released", 128'(dl_wait), 128'(0));
    dl_addr = a;
    dl_data = d;
    dl_wr   = 1'b1;
    @(posedge clk1x);
    #1;
    dl_wr = 1'b0;
  endtask

  task automatic start_dl();
    dl_active = 1'b1;
    @(posedge clk1x);
    #1;
  endtask

  task automatic do_download(input string tag, input logic [1:0] fmt_exp,
                             input logic [26:0] size_exp);
    int start_cnt = load_done_cnt;
    int guard = 0;
    start_dl();
    foreach (vec[i]) send(27'(2 * i), vec[i]);
    dl_active = 1'b0;
    while (load_done_cnt == start_cnt && guard < 3000) begin
      @(posedge clk1x);
      #1;
      guard++;
    end
    repeat (5) @(posedge clk1x);
    #1;
    check({tag, "_load_done_pulses"}, 128'(load_done_cnt - start_cnt), 128'(1));
    check({tag, "_rom_format"}, 128'(rom_format), 128'(fmt_exp));
    check({tag, "_rom_size"}, 128'(rom_size), 128'(size_exp));
    check({tag, "_overflow"}, 128'(overflow), 128'(0));
    check({tag, "_words_left"}, 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    int guard;
    int req_before;
    repeat (3) @(posedge clk1x);
    #1;
    check("reset_outputs_a", 128'({dl_wait, mem_req, mem_addr, mem_data}), 128'(0));
    check("reset_outputs_b", 128'({rom_format, rom_size, load_done, overflow}), 128'(0));
    reset_n = 1'b1;
    repeat (2) @(posedge clk1x);
    #1;

    vec = '{16'h3780, 16'h4012};
    expect_word(27'h0100000, 32'h40123780);
    do_download("z64", 2'd0, 27'd4);

    vec = '{16'h8037, 16'h1240};
    expect_word(27'h0100000, 32'h40123780);
    do_download("v64", 2'd1, 27'd4);

    vec = '{16'h1240, 16'h8037};
    expect_word(27'h0100000, 32'h40123780);
    do_download("n64", 2'd2, 27'd4);

    // Back-pressure: slow SDRAM, 16 halfwords, z64 so word k = {h[2k+1], h[2k]}.
    vec.delete();
    for (int i = 0; i < 16; i++) vec.push_back((i == 0) ? 16'h3780 : 16'h1000 + 16'(i));
    for (int k = 0; k < 8; k++) expect_word(27'h0100000 + 27'(4 * k), {vec[2*k+1], vec[2*k]});
    ready_delay = 50;
    bp_arm      = 1'b1;
    do_download("bp", 2'd0, 27'd32);
    check("bp_wait_rose", 128'(bp_seen), 128'(1));
    bp_arm      = 1'b0;
    ready_delay = 2;

    vec = '{16'h3780, 16'h4012, 16'h1111, 16'h2222, 16'h3333};
    expect_word(27'h0100000, 32'h40123780);
    expect_word(27'h0100004, 32'h22221111);
    expect_word(27'h0100008, 32'h00003333);
    do_download("tail", 2'd0, 27'd10);

    // Reset with a request outstanding and never acknowledged.
    resp_en = 1'b0;
    expect_word(27'h0100000, 32'h40123780);
    start_dl();
    send(27'd0, 16'h3780);
    send(27'd2, 16'h4012);
    guard = 0;
    while (!mem_req && guard < 50) begin
      @(posedge clk1x);
      #1;
      guard++;
    end
    check("rst_req_seen", 128'(mem_req), 128'(1));
    repeat (2) @(posedge clk1x);
    #1;
    reset_n   = 1'b0;
    dl_active = 1'b0;
    #1;
    check("rst_mid_outputs_a", 128'({dl_wait, mem_req, mem_addr, mem_data}), 128'(0));
    check("rst_mid_outputs_b", 128'({rom_format, rom_size, load_done, overflow}), 128'(0));
    repeat (3) @(posedge clk1x);
    #1;
    reset_n    = 1'b1;
    req_before = req_cnt;
    stale_pulses++;
    repeat (6) @(posedge clk1x);
    #1;
    check("rst_stale_ready_no_req", 128'(req_cnt - req_before), 128'(0));
    resp_en = 1'b1;

    vec = '{16'h1240, 16'h8037};
    expect_word(27'h0100000, 32'h40123780);
    do_download("post_rst", 2'd2, 27'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
